calc_run_sequencer: RTL and testbench
=====================================

# calc_run_sequencer

Sequences one calculation through the single-cycle RISC-V core and owns the shared data-memory port. On `start` from the calculator front-end it:
- writes the two operands and the operation code into data memory;
- restarts and enables the CPU for a bounded cycle budget, or until the CPU signals halt;
- reads the result word back and holds it for display.

It sits between the calculator front-end, the CPU data-memory interface and the data memory, and is the only master that drives the memory port.

## Interface
Parameters:
- `OPA_ADDR`, 220, byte address of operand A word
- `OPB_ADDR`, 260, byte address of operand B word
- `OP_ADDR`, 300, byte address of operation-code word
- `RESULT_ADDR`, 460, byte address of result word
- `RUN_CYCLES`, 200, maximum CPU-enabled cycles per run (must be ≥1)

Ports:
- `hz100`  in  1  system clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request to begin a calculation (level sampled each edge)
- `clear`  in  1  synchronous abort/clear
- `opA`, `opB`  in  32  operands, captured when `start` is accepted
- `opCode`  in  4  one-hot operation (add 1000, sub 0100, mul 0010, div 0001), captured with the operands
- `cpuHalt`  in  1  CPU reports program finished
- `cpuAddr`, `cpuWData`  in  32  CPU data-memory request
- `cpuWrite`, `cpuRead`  in  1  CPU data-memory strobes
- `cpuRData`  out  32  read data returned to the CPU
- `memAddr`, `memWData`  out  32  data-memory port
- `memWrite`, `memRead`  out  1  data-memory strobes
- `memRData`  in  32  data-memory read data; combinational, valid in the same cycle
- `cpuRestart`  out  1  one-cycle pulse that resets the CPU program counter
- `cpuEnable`  out  1  CPU clock enable
- `busy`  out  1  high in every state except IDLE and DONE
- `done`  out  1  `result` is valid
- `result`  out  32  captured result word

## Operation
- States:
  - IDLE → WR_A → WR_B → WR_OP → RESTART → RUN → RD_RES → DONE.
  - DONE → WR_A on `start`.
  - Any state → IDLE on `clear`.
- IDLE/DONE accept `start`: capture `opA`/`opB`/`opCode` into internal registers; go to WR_A.
- WR_A / WR_B / WR_OP:
  - `memWrite`=1; `memAddr`= OPA_ADDR / OPB_ADDR / OP_ADDR.
  - `memWData`= captured A / B / {28'b0, op}.
- RESTART: `cpuRestart`=1; load the budget counter with RUN_CYCLES.
- RUN:
  - `cpuEnable`=1; the memory port is muxed to the CPU (`memAddr`=`cpuAddr`, strobes and data passed through, `cpuRData`=`memRData`).
  - Counter decrements each cycle.
  - Leave to RD_RES when the counter reaches 1 or `cpuHalt`=1, whichever comes first; both in the same cycle gives the same transition.
- RD_RES: `memRead`=1, `memAddr`=RESULT_ADDR; `result`←`memRData` at the edge; go to DONE.
- DONE: `done`=1; `result` held.
- Outside RUN: CPU strobes are ignored and `cpuRData`=0.
- When the sequencer does not own the port (IDLE, RESTART, DONE), all memory strobes are 0 and `memAddr`/`memWData`=0.
- Boundary rules:
  - `start` while `busy` is ignored; captured operands do not change.
  - `clear` and `start` in the same cycle: `clear` wins.
  - `clear` returns to IDLE and zeroes `result`.
  - Input operand changes after acceptance have no effect.
  - The counter never underflows.

## Timing
- Reset (asynchronous, immediate): state=IDLE; all outputs 0 (`cpuEnable`, `cpuRestart`, `busy`, `done`, `result`, `mem*`, `cpuRData`).
- `start` sampled at edge k:
  - WR_A is cycle k+1, WR_B is k+2, WR_OP is k+3.
  - RESTART is k+4.
  - RUN occupies k+5 … k+4+RUN_CYCLES without a halt.
  - RD_RES is k+5+RUN_CYCLES.
  - `done`=1 from k+6+RUN_CYCLES.
- `cpuHalt` high in RUN cycle j: RD_RES in j+1.
- All outputs are Moore decodes of state, except RUN passthrough (combinational from the `cpu*` inputs) and `cpuRData` (combinational from `memRData`).
- Reset asserted mid-RUN: `cpuEnable` drops asynchronously; memory is not written by the sequencer afterwards.

## Structure
- Shared package `calc_pkg`:
  - `seq_state_t` enum: IDLE, WR_A, WR_B, WR_OP, RESTART, RUN, RD_RES, DONE.
  - Opcode constants `OP_ADD`, `OP_SUB`, `OP_MUL`, `OP_DIV`.
  - Default address constants.
- One sub-module, `run_budget_counter`:
  - Inputs: load, enable.
  - Output: `expire`.
  - Width $clog2(RUN_CYCLES+1); saturates at 0.
- Port mux and FSM live in the top.

## Test plan
- Reset, then `start` with A=12, B=7, op=1000:
  - writes 12@220, 7@260, 8@300 in three consecutive cycles;
  - `cpuRestart` pulse the next cycle;
  - `cpuEnable` high for exactly 200 cycles;
  - read @460;
  - `done`=1 with `result`= the memory value.
- During RUN, CPU writes 19@460; `cpuHalt` pulses at RUN cycle 10 → RD_RES next cycle, `result`=19, `cpuEnable` was high for 10 cycles.
- `start` pulsed again during RUN with A=99 → ignored; the later writes still use the original operands; a new `start` in DONE rewrites 99@220.
- `clear` together with `start` in IDLE → stays IDLE. `clear` during RUN → next cycle IDLE, `cpuEnable`=0, `result`=0, `done`=0.
- Reset asserted mid-WR_B → outputs 0 immediately; after release, no further memory writes until a new `start`. CPU strobes in IDLE never reach `memWrite`.

Source files
------------

// File: rtl/calc_pkg.sv
// ------------------------------------------------------------------
// calc_pkg : shared states, opcodes and default addresses. rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package calc_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_A    = 3'd1,
      WR_B    = 3'd2,
      WR_OP   = 3'd3,
      RESTART = 3'd4,
      RUN     = 3'd5,
      RD_RES  = 3'd6,
      DONE    = 3'd7
   } seq_state_t;

   localparam logic [3:0] OP_ADD = 4'b1000;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_MUL = 4'b0010;
   localparam logic [3:0] OP_DIV = 4'b0001;

   localparam logic [31:0] DEF_OPA_ADDR    = 32'd220;
   localparam logic [31:0] DEF_OPB_ADDR    = 32'd260;
   localparam logic [31:0] DEF_OP_ADDR     = 32'd300;
   localparam logic [31:0] DEF_RESULT_ADDR = 32'd460;
   localparam int          DEF_RUN_CYCLES  = 200;

endpackage

`default_nettype wire

// File: rtl/run_budget_counter.sv
// ------------------------------------------------------------------
// run_budget_counter : saturating down-counter bounding a CPU run. rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module run_budget_counter #(
   parameter int RUN_CYCLES = 200
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic enable,
   output logic expire
);

   localparam int CW = $clog2(RUN_CYCLES + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= CW'(RUN_CYCLES);
      end else if (enable && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   // count==1 marks the final permitted run cycle
   assign expire = (count <= CW'(1));

endmodule

`default_nettype wire

// File: rtl/calc_run_sequencer.sv
// ------------------------------------------------------------------
// calc_run_sequencer : loads operands, runs the CPU, reads back result. rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module calc_run_sequencer
   import calc_pkg::*;
#(
   parameter logic [31:0] OPA_ADDR    = DEF_OPA_ADDR,
   parameter logic [31:0] OPB_ADDR    = DEF_OPB_ADDR,
   parameter logic [31:0] OP_ADDR     = DEF_OP_ADDR,
   parameter logic [31:0] RESULT_ADDR = DEF_RESULT_ADDR,
   parameter int          RUN_CYCLES  = DEF_RUN_CYCLES
) (
   input  logic        hz100,
   input  logic        reset,
   input  logic        start,
   input  logic        clear,
   input  logic [31:0] opA,
   input  logic [31:0] opB,
   input  logic [3:0]  opCode,
   input  logic        cpuHalt,
   input  logic [31:0] cpuAddr,
   input  logic [31:0] cpuWData,
   input  logic        cpuWrite,
   input  logic        cpuRead,
   output logic [31:0] cpuRData,
   output logic [31:0] memAddr,
   output logic [31:0] memWData,
   output logic        memWrite,
   output logic        memRead,
   input  logic [31:0] memRData,
   output logic        cpuRestart,
   output logic        cpuEnable,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   seq_state_t  state;
   seq_state_t  nxt;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [3:0]  op_code;
   logic        seq_write;
   logic        seq_read;
   logic [31:0] seq_addr;
   logic [31:0] seq_wdata;
   logic        accept;
   logic        expire;

   run_budget_counter #(
      .RUN_CYCLES (RUN_CYCLES)
   ) u_budget (
      .clk    (hz100),
      .rst_n  (reset),
      .load   (state == RESTART),
      .enable (state == RUN),
      .expire (expire)
   );

   assign accept = start && !clear && ((state == IDLE) || (state == DONE));

   always_comb begin
      nxt = state;
      if (clear) begin
         nxt = IDLE;
      end else begin
         case (state)
            IDLE, DONE: if (start) nxt = WR_A;
            WR_A:       nxt = WR_B;
            WR_B:       nxt = WR_OP;
            WR_OP:      nxt = RESTART;
            RESTART:    nxt = RUN;
            RUN:        if (expire || cpuHalt) nxt = RD_RES;
            RD_RES:     nxt = DONE;
            default:    nxt = IDLE;
         endcase
      end
   end

   // Outputs are registered from the next state so they stay pure state decodes
   always_ff @(posedge hz100 or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         op_a       <= '0;
         op_b       <= '0;
         op_code    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         cpuEnable  <= 1'b0;
         cpuRestart <= 1'b0;
         seq_write  <= 1'b0;
         seq_read   <= 1'b0;
         seq_addr   <= '0;
         seq_wdata  <= '0;
         result     <= '0;
      end else begin
         state <= nxt;
         if (accept) begin
            op_a    <= opA;
            op_b    <= opB;
            op_code <= opCode;
         end
         busy       <= !((nxt == IDLE) || (nxt == DONE));
         done       <= (nxt == DONE);
         cpuEnable  <= (nxt == RUN);
         cpuRestart <= (nxt == RESTART);
         seq_write  <= (nxt == WR_A) || (nxt == WR_B) || (nxt == WR_OP);
         seq_read   <= (nxt == RD_RES);
         // WR_A is only entered on accept, so operand A comes straight from the port
         case (nxt)
            WR_A: begin
               seq_addr  <= OPA_ADDR;
               seq_wdata <= opA;
            end
            WR_B: begin
               seq_addr  <= OPB_ADDR;
               seq_wdata <= op_b;
            end
            WR_OP: begin
               seq_addr  <= OP_ADDR;
               seq_wdata <= {28'b0, op_code};
            end
            RD_RES: begin
               seq_addr  <= RESULT_ADDR;
               seq_wdata <= '0;
            end
            default: begin
               seq_addr  <= '0;
               seq_wdata <= '0;
            end
         endcase
         if (clear) begin
            result <= '0;
         end else if (state == RD_RES) begin
            result <= memRData;
         end
      end
   end

   always_comb begin
      if (state == RUN) begin
         memAddr  = cpuAddr;
         memWData = cpuWData;
         memWrite = cpuWrite;
         memRead  = cpuRead;
         cpuRData = memRData;
      end else begin
         memAddr  = seq_addr;
         memWData = seq_wdata;
         memWrite = seq_write;
         memRead  = seq_read;
         cpuRData = '0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_calc_run_sequencer.sv
// ------------------------------------------------------------------
// tb_calc_run_sequencer : scoreboard bench for calc_run_sequencer. rev 1.0
// ------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_calc_run_sequencer;
   import calc_pkg::*;

   localparam int KIND_WR = 0, KIND_RST = 1, KIND_RD = 2, KIND_DONE = 3;

   logic        hz100 = 1'b0, reset = 1'b0, start = 1'b0, clear = 1'b0;
   logic [31:0] opA = '0, opB = '0;
   logic [3:0]  opCode = '0;
   logic        cpuHalt = 1'b0, cpuWrite = 1'b0, cpuRead = 1'b0;
   logic [31:0] cpuAddr = '0, cpuWData = '0;
   logic [31:0] cpuRData, memAddr, memWData, memRData, result;
   logic        memWrite, memRead, cpuRestart, cpuEnable, busy, done;

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [31:0] data;
   } ev_t;

   ev_t         q[$];
   int          total = 0, bad = 0, cyc = 0, k_edge = 0, en_cnt = 0;
   logic        prev_done = 1'b0;
   logic [31:0] mem [0:127];
   logic        pl_en = 1'b0;
   logic [6:0]  pl_idx = '0;
   logic [31:0] pl_data = '0;

   calc_run_sequencer dut (
      .hz100(hz100), .reset(reset), .start(start), .clear(clear),
      .opA(opA), .opB(opB), .opCode(opCode), .cpuHalt(cpuHalt),
      .cpuAddr(cpuAddr), .cpuWData(cpuWData), .cpuWrite(cpuWrite), .cpuRead(cpuRead),
      .cpuRData(cpuRData), .memAddr(memAddr), .memWData(memWData),
      .memWrite(memWrite), .memRead(memRead), .memRData(memRData),
      .cpuRestart(cpuRestart), .cpuEnable(cpuEnable), .busy(busy), .done(done),
      .result(result)
   );

   always #5 hz100 = ~hz100;

   assign memRData = mem[memAddr[8:2]];
   always @(posedge hz100) begin
      if (memWrite) mem[memAddr[8:2]] <= memWData;
      else if (pl_en) mem[pl_idx] <= pl_data;
   end

   initial forever begin
      @(posedge hz100);
      cyc++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
      end
   endtask

   task automatic push(input int kind, input logic [31:0] addr, input logic [31:0] data);
      ev_t e;
      e.kind = kind;
      e.addr = addr;
      e.data = data;
      q.push_back(e);
   endtask

   task automatic expect_ev(input int kind, input logic [31:0] addr, input logic [31:0] data);
      ev_t e;
      total++;
      if (q.size() == 0) begin
         bad++;
         $display("FAIL unexpected_event: got kind=%0d addr=%0d data=%0d, expected none", kind, addr, data);
      end else begin
         e = q.pop_front();
         if (e.kind != kind || e.addr !== addr || e.data !== data) begin
            bad++;
            $display("FAIL event: got kind=%0d addr=%0d data=%0d expected kind=%0d addr=%0d data=%0d",
                     kind, addr, data, e.kind, e.addr, e.data);
         end
      end
   endtask

   // Monitor: every observable port transaction is matched against the queue
   initial forever begin
      @(negedge hz100);
      if (reset) begin
         if (cpuRestart) begin
            en_cnt = 0;
            expect_ev(KIND_RST, 32'd0, 32'd0);
         end
         if (cpuEnable) en_cnt++;
         if (memWrite) expect_ev(KIND_WR, memAddr, memWData);
         if (memRead && !cpuEnable) expect_ev(KIND_RD, memAddr, en_cnt);
         if (done && !prev_done) expect_ev(KIND_DONE, 32'd0, result);
         prev_done = done;
      end else begin
         prev_done = 1'b0;
      end
   end

   task automatic step();
      @(posedge hz100);
      #1;
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      start  = 1'b1;
      opA    = a;
      opB    = b;
      opCode = op;
      k_edge = cyc + 1;
   endtask

   task automatic wait_done(input string name, input int exp_lat);
      int n = 0;
      while (!done && n < 400) begin
         step();
         n++;
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL %s: done never rose, got 0 expected 1", name);
      end else begin
         chk(name, cyc - k_edge, exp_lat);
      end
   endtask

   task automatic wait_enable(input string name);
      int n = 0;
      while (!cpuEnable && n < 20) begin
         step();
         n++;
      end
      if (!cpuEnable) begin
         total++;
         bad++;
         $display("FAIL %s: cpuEnable never rose, got 0 expected 1", name);
      end
   endtask

   initial begin
      #12;
      chk("rst_cpuEnable", cpuEnable, 0);
      chk("rst_cpuRestart", cpuRestart, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_strobes", {memWrite, memRead}, 0);
      chk("rst_memAddr", memAddr, 0);
      chk("rst_cpuRData", cpuRData, 0);
      step();
      reset   = 1'b1;
      pl_en   = 1'b1;
      pl_idx  = 7'd115;
      pl_data = 32'hCAFE_0001;
      step();
      pl_en = 1'b0;

      // Full-budget run
      push(KIND_WR, 32'd220, 32'd12);
      push(KIND_WR, 32'd260, 32'd7);
      push(KIND_WR, 32'd300, 32'd8);
      push(KIND_RST, 32'd0, 32'd0);
      push(KIND_RD, 32'd460, 32'd200);
      push(KIND_DONE, 32'd0, 32'hCAFE_0001);
      issue(32'd12, 32'd7, OP_ADD);
      step();
      start = 1'b0;
      wait_done("full_run_latency", 205);
      chk("full_run_busy", busy, 0);

      // Halted run with CPU traffic and ignored starts
      push(KIND_WR, 32'd220, 32'd5);
      push(KIND_WR, 32'd260, 32'd3);
      push(KIND_WR, 32'd300, 32'd4);
      push(KIND_RST, 32'd0, 32'd0);
      push(KIND_WR, 32'd460, 32'd19);
      push(KIND_RD, 32'd460, 32'd10);
      push(KIND_DONE, 32'd0, 32'd19);
      issue(32'd5, 32'd3, OP_SUB);
      step();
      opA = 32'd99;
      opB = 32'd99;
      opCode = OP_DIV;
      step();
      start = 1'b0;
      wait_enable("halt_run_enable");
      step();
      step();
      cpuWrite = 1'b1;
      cpuAddr  = 32'd460;
      cpuWData = 32'd19;
      step();
      cpuWrite = 1'b0;
      cpuRead  = 1'b1;
      cpuAddr  = 32'd220;
      @(negedge hz100);
      chk("run_cpuRData", cpuRData, 32'd5);
      step();
      cpuRead = 1'b0;
      cpuAddr = '0;
      start   = 1'b1;
      opA     = 32'd77;
      step();
      start = 1'b0;
      repeat (4) step();
      cpuHalt = 1'b1;
      step();
      cpuHalt = 1'b0;
      wait_done("halt_run_latency", 15);

      // Restart from DONE, then clear mid-run
      push(KIND_WR, 32'd220, 32'd99);
      push(KIND_WR, 32'd260, 32'd1);
      push(KIND_WR, 32'd300, 32'd2);
      push(KIND_RST, 32'd0, 32'd0);
      issue(32'd99, 32'd1, OP_MUL);
      step();
      start = 1'b0;
      wait_enable("clear_run_enable");
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clear_cpuEnable", cpuEnable, 0);
      chk("clear_done", done, 0);
      chk("clear_result", result, 0);
      chk("clear_busy", busy, 0);

      // clear beats start in IDLE
      issue(32'd55, 32'd55, OP_ADD);
      clear = 1'b1;
      step();
      start = 1'b0;
      clear = 1'b0;
      chk("clr_start_busy", busy, 0);
      step();
      chk("clr_start_busy2", busy, 0);

      // Reset during WR_B
      push(KIND_WR, 32'd220, 32'd1);
      issue(32'd1, 32'd2, OP_DIV);
      step();
      start = 1'b0;
      step();
      reset = 1'b0;
      #1;
      chk("midrst_memWrite", memWrite, 0);
      chk("midrst_memAddr", memAddr, 0);
      chk("midrst_busy", busy, 0);
      step();
      reset    = 1'b1;
      cpuWrite = 1'b1;
      cpuRead  = 1'b1;
      cpuAddr  = 32'd80;
      cpuWData = 32'd9;
      for (int i = 0; i < 4; i++) begin
         @(negedge hz100);
         chk("idle_memWrite", memWrite, 0);
         chk("idle_cpuRData", cpuRData, 0);
      end
      cpuWrite = 1'b0;
      cpuRead  = 1'b0;
      step();
      chk("queue_empty", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
